// File: rtl/fir_mac_512_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_512_pkg
// Purpose  : Default geometry and FSM state encodings for the single-MAC FIR
//            stage (fir_mac_512) and its history RAM.
// Revision : 1.0  initial release
// ============================================================================
package fir_mac_512_pkg;

    localparam int c_NTAPS     = 512;  // filter length, 2**c_AW
    localparam int c_AW        = 9;    // history/coefficient address width
    localparam int c_DW        = 16;   // sample and output width
    localparam int c_CW        = 16;   // coefficient width
    localparam int c_ACC_W     = 41;   // c_DW + c_CW + c_AW
    localparam int c_OUT_SHIFT = 15;   // output scaling shift
    localparam int c_DRAIN_CYC = 3;    // cycles needed to empty the MAC pipeline

    typedef enum logic [2:0] {
        ST_CLR   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fir_hist_ram.sv
`default_nettype none
// ============================================================================
// Module   : fir_hist_ram
// Purpose  : Sample history store, inferred simple-dual-port block RAM with
//            one write port and one registered read port (1-cycle latency,
//            aligned with the coefficient RAM read port).
// Revision : 1.0  initial release
// ============================================================================
module fir_hist_ram
    import fir_mac_512_pkg::*;
#(
    parameter int AW = c_AW,
    parameter int DW = c_DW
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    // Write port and registered read port; no reset so it maps onto BSRAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fir_mac_512.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_512
// Purpose  : Time-multiplexed single-MAC FIR stage for one microphone channel.
//            One input sample in, NTAPS MAC cycles against the external
//            coefficient RAM, one rounded 16-bit sample out.
//            Build option: FIR_SAT_EN defined -> output saturates,
//            undefined -> output wraps (low DW bits kept).
// Revision : 1.0  initial release
// ============================================================================
module fir_mac_512
    import fir_mac_512_pkg::*;
#(
    parameter int NTAPS     = c_NTAPS,
    parameter int AW        = c_AW,
    parameter int DW        = c_DW,
    parameter int CW        = c_CW,
    parameter int ACC_W     = c_ACC_W,
    parameter int OUT_SHIFT = c_OUT_SHIFT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW-1:0] coef_ad,
    output logic          coef_ce,
    output logic          coef_oce,
    input  logic [CW-1:0] coef_dout
);

    localparam int                      c_PW         = DW + CW;
    localparam logic [AW-1:0]           c_LAST       = AW'(NTAPS - 1);
    localparam logic [AW-1:0]           c_DRAIN_LAST = AW'(c_DRAIN_CYC - 1);
    localparam logic signed [ACC_W-1:0] c_RND        = ACC_W'(1) <<< (OUT_SHIFT - 1);

    state_t                   r_state, w_state_nx;
    logic [AW-1:0]            r_cnt;
    logic [AW-1:0]            r_wp;
    logic                     r_v1;
    logic                     r_pv;
    logic signed [c_PW-1:0]   r_prod;
    logic signed [ACC_W-1:0]  r_acc;
    logic [DW-1:0]            r_m_data;

    logic                     w_accept;
    logic                     w_load;
    logic                     w_hwe;
    logic [AW-1:0]            w_hwaddr;
    logic [DW-1:0]            w_hwdata;
    logic [DW-1:0]            w_hist_q;
    logic signed [ACC_W-1:0]  w_round;
    logic signed [ACC_W-1:0]  w_shift;
    logic [DW-1:0]            w_narrow;

    assign coef_oce = 1'b1;
    assign m_data   = r_m_data;
    assign w_accept = (r_state == ST_IDLE) && s_valid;
    assign w_load   = (r_state == ST_DRAIN) && (r_cnt == c_DRAIN_LAST);

    // CLR sweeps zeros through the history; otherwise an accepted sample lands at wp.
    assign w_hwe    = (r_state == ST_CLR) || w_accept;
    assign w_hwaddr = (r_state == ST_CLR) ? r_cnt : r_wp;
    assign w_hwdata = (r_state == ST_CLR) ? '0 : s_data;

    fir_hist_ram #(
        .AW (AW),
        .DW (DW)
    ) u_hist (
        .clk     (clk),
        .i_we    (w_hwe),
        .i_waddr (w_hwaddr),
        .i_wdata (w_hwdata),
        .i_re    (r_state == ST_MAC),
        .i_raddr (r_wp - r_cnt),
        .o_rdata (w_hist_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLR;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and handshake/coefficient-port outputs.
    always_comb begin
        w_state_nx = r_state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        coef_ce    = 1'b0;
        coef_ad    = '0;
        case (r_state)
            ST_CLR: begin
                if (r_cnt == c_LAST) w_state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                s_ready = 1'b1;
                if (s_valid) w_state_nx = ST_MAC;
            end
            ST_MAC: begin
                coef_ce = 1'b1;
                coef_ad = r_cnt;
                if (r_cnt == c_LAST) w_state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_cnt == c_DRAIN_LAST) w_state_nx = ST_OUT;
            end
            ST_OUT: begin
                m_valid = 1'b1;
                if (m_ready) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_CLR;
        endcase
    end

    // Shared step counter: CLR address, MAC tap index, DRAIN cycle; restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_state_nx != r_state) begin
            r_cnt <= '0;
        end else if (r_state == ST_CLR || r_state == ST_MAC || r_state == ST_DRAIN) begin
            r_cnt <= r_cnt + AW'(1);
        end
    end

    // MAC pipeline: RAM outputs -> registered product -> accumulator, plus output register and wp.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1     <= 1'b0;
            r_pv     <= 1'b0;
            r_prod   <= '0;
            r_acc    <= '0;
            r_wp     <= '0;
            r_m_data <= '0;
        end else begin
            r_v1   <= (r_state == ST_MAC);
            r_pv   <= r_v1;
            r_prod <= c_PW'($signed(coef_dout)) * c_PW'($signed(w_hist_q));
            if (w_accept) begin
                r_acc <= '0;
            end else if (r_pv) begin
                r_acc <= r_acc + ACC_W'(r_prod);
            end
            if (w_load) begin
                r_m_data <= w_narrow;
                r_wp     <= r_wp + AW'(1);
            end
        end
    end

    assign w_round = r_acc + c_RND;
    assign w_shift = w_round >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] c_MAXV = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_MINV = ~c_MAXV;

    // Clamp the scaled result into the signed DW-bit range.
    always_comb begin
        w_narrow = DW'(w_shift);
        if (w_shift > c_MAXV) begin
            w_narrow = {1'b0, {(DW-1){1'b1}}};
        end else if (w_shift < c_MINV) begin
            w_narrow = {1'b1, {(DW-1){1'b0}}};
        end
    end
`else
    // Keep the low DW bits of the scaled result (wraps on overflow).
    always_comb begin
        w_narrow = DW'(w_shift);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_512.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_512
// Purpose  : Self-checking bench for fir_mac_512 (default build or FIR_SAT_EN).
//            Main instance at OUT_SHIFT=15, a twin at OUT_SHIFT=1, and a
//            32-tap instance for long runs through the write-pointer wrap.
// Revision : 1.0  initial release
// ============================================================================
module tb_fir_mac_512;

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [15:0] s_data, m_data, coef_dout;
    logic [8:0]  coef_ad;
    logic        coef_ce, coef_oce;

    logic        s_ready1, m_valid1, coef_ce1, coef_oce1;
    logic [15:0] m_data1, coef_dout1;
    logic [8:0]  coef_ad1;

    logic        sm_valid, sm_ready, sm_mvalid, sm_ce, sm_oce;
    logic [15:0] sm_data, sm_mdata, sm_dout;
    logic [4:0]  sm_ad;

    logic [15:0] coef [0:511];
    logic [15:0] h_m  [0:511];
    int          wp_m;
    int          n_checks = 0;
    int          n_errors = 0;

    fir_mac_512 u_dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .coef_ad(coef_ad),
        .coef_ce(coef_ce), .coef_oce(coef_oce), .coef_dout(coef_dout)
    );

    fir_mac_512 #(.OUT_SHIFT(1)) u_dut1 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .coef_ad(coef_ad1),
        .coef_ce(coef_ce1), .coef_oce(coef_oce1), .coef_dout(coef_dout1)
    );

    fir_mac_512 #(.NTAPS(32), .AW(5), .DW(16), .CW(16), .ACC_W(37), .OUT_SHIFT(15)) u_small (
        .clk(clk), .reset(reset), .s_valid(sm_valid), .s_ready(sm_ready), .s_data(sm_data),
        .m_valid(sm_mvalid), .m_ready(1'b1), .m_data(sm_mdata), .coef_ad(sm_ad),
        .coef_ce(sm_ce), .coef_oce(sm_oce), .coef_dout(sm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coefficient RAM read ports: registered, 1-cycle latency.
    always @(posedge clk) begin
        if (coef_ce)  coef_dout  <= coef[coef_ad];
        if (coef_ce1) coef_dout1 <= coef[coef_ad1];
        if (sm_ce)    sm_dout    <= coef[sm_ad];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference filter: sum c[k]*x[wp-k], round half up, shift, narrow.
    function automatic logic [15:0] model(input int ntaps, input int shift, input int wp);
        longint      acc;
        logic [63:0] r;
        acc = 0;
        for (int k = 0; k < ntaps; k++) begin
            acc += longint'($signed(coef[k])) * longint'($signed(h_m[(wp - k) & (ntaps - 1)]));
        end
        acc = (acc + (longint'(1) <<< (shift - 1))) >>> shift;
`ifdef FIR_SAT_EN
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`endif
        r = acc;
        return r[15:0];
    endfunction

    // One sample in, one sample out with m_ready=1; returns outputs and latency.
    task automatic xfer(input bit sm, input logic [15:0] d, output logic [15:0] q,
                        output logic [15:0] q1, output int lat);
        int n;
        n = 0;
        while (!(sm ? sm_ready : s_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sm) begin sm_valid = 1'b1; sm_data = d; end
        else    begin s_valid  = 1'b1; s_data  = d; end
        @(negedge clk);
        sm_valid = 1'b0;
        s_valid  = 1'b0;
        lat = 1;
        while (!(sm ? sm_mvalid : m_valid) && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        chk("out_timeout", 32'(lat < 2000), 32'd1);
        q  = sm ? sm_mdata : m_data;
        q1 = m_data1;
        @(negedge clk);
    endtask

    task automatic clr_model();
        for (int i = 0; i < 512; i++) h_m[i] = 16'h0000;
        wp_m = 0;
    endtask

    // Counts CLR cycles after reset release and whether m_valid appeared.
    task automatic release_and_count(output int cnt, output bit mv_seen);
        reset   = 1'b0;
        cnt     = 0;
        mv_seen = 1'b0;
        while (!s_ready && cnt < 1000) begin
            if (m_valid) mv_seen = 1'b1;
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [7];
        logic [15:0] q, q1, e, hq;
        int          lat, cnt;
        bit          mv, hold_ok;

        coef[0] = 16'h0005; coef[1] = 16'hFFE9; coef[2] = 16'h0100; coef[3] = 16'h8000;
        coef[4] = 16'h7FFF; coef[5] = 16'hFFFF; coef[6] = 16'h0000;
        for (int i = 7; i < 512; i++) coef[i] = 16'($urandom);

        tbl[0] = '{16'h7FFF, 16'h0005};
        tbl[1] = '{16'h0000, 16'hFFE9};
        tbl[2] = '{16'h0000, 16'h0100};
        tbl[3] = '{16'h0000, 16'h8001};
        tbl[4] = '{16'h0000, 16'h7FFE};
        tbl[5] = '{16'h0000, 16'hFFFF};
        tbl[6] = '{16'h0000, 16'h0000};

        reset = 1'b1; s_valid = 1'b0; s_data = 16'h0; m_ready = 1'b1;
        sm_valid = 1'b0; sm_data = 16'h0;
        clr_model();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data",  32'(m_data),  32'd0);
        chk("rst_coef_ad", 32'(coef_ad), 32'd0);
        chk("rst_coef_ce", 32'(coef_ce), 32'd0);
        chk("rst_coef_oce", 32'(coef_oce), 32'd1);
        chk("rst_oce_twin", 32'(coef_oce1 & sm_oce), 32'd1);

        // CLR length after reset release
        release_and_count(cnt, mv);
        chk("clr_cycles", 32'(cnt), 32'd512);
        chk("clr_no_mvalid", 32'(mv), 32'd0);
        chk("twin_s_ready", 32'(s_ready1), 32'd1);

        // Impulse response, table driven, plus the OUT_SHIFT=1 twin on the first output
        for (int i = 0; i < 7; i++) begin
            h_m[wp_m] = tbl[i].din;
            e = model(512, 15, wp_m);
            xfer(1'b0, tbl[i].din, q, q1, lat);
            chk($sformatf("imp_tbl_%0d", i), 32'(q), 32'(tbl[i].dout));
            chk($sformatf("imp_model_%0d", i), 32'(q), 32'(e));
            if (i == 0) begin
                chk("imp_latency", 32'(lat), 32'd516);
`ifdef FIR_SAT_EN
                chk("shift1_impulse", 32'(q1), 32'h7FFF);
`else
                chk("shift1_impulse", 32'(q1), 32'h3FFE);
`endif
            end
            wp_m = (wp_m + 1) & 511;
        end

        // Backpressure: hold m_ready low, offer a sample that must not be taken
        cnt = 0;
        while (!s_ready && cnt < 2000) begin @(negedge clk); cnt++; end
        h_m[wp_m] = 16'h0042;
        e = model(512, 15, wp_m);
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 16'h0042;
        @(negedge clk);
        s_valid = 1'b0;
        cnt = 0;
        while (!m_valid && cnt < 2000) begin @(negedge clk); cnt++; end
        chk("hold_first", 32'(m_data), 32'(e));
        hq = m_data;
        hold_ok = 1'b1;
        s_valid = 1'b1; s_data = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!m_valid || m_data !== hq || s_ready) hold_ok = 1'b0;
        end
        chk("hold_stable", 32'(hold_ok), 32'd1);
        m_ready = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        chk("post_xfer_s_ready", 32'(s_ready), 32'd1);
        chk("post_xfer_m_valid", 32'(m_valid), 32'd0);
        wp_m = (wp_m + 1) & 511;
        h_m[wp_m] = 16'h0000;
        e = model(512, 15, wp_m);
        xfer(1'b0, 16'h0000, q, q1, lat);
        chk("after_hold_model", 32'(q), 32'(e));
        wp_m = (wp_m + 1) & 511;

        // Reset in the middle of MAC (tap 200)
        cnt = 0;
        while (!s_ready && cnt < 2000) begin @(negedge clk); cnt++; end
        s_valid = 1'b1; s_data = 16'h7FFF;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (200) @(negedge clk);
        chk("tap200_coef_ad", 32'(coef_ad), 32'd200);
        reset = 1'b1;
        mv = 1'b0;
        repeat (2) begin @(negedge clk); if (m_valid) mv = 1'b1; end
        chk("midrst_coef_ce", 32'(coef_ce), 32'd0);
        release_and_count(cnt, hold_ok);
        chk("reclr_cycles", 32'(cnt), 32'd512);
        chk("midrst_no_mvalid", 32'(mv | hold_ok), 32'd0);
        clr_model();
        xfer(1'b0, 16'h7FFF, q, q1, lat);
        chk("reimp_0", 32'(q), 32'h0005);
        chk("reimp_latency", 32'(lat), 32'd516);
        xfer(1'b0, 16'h0000, q, q1, lat);
        chk("reimp_1", 32'(q), 32'hFFE9);

        // Long random run on the 32-tap instance, wrapping wp many times
        clr_model();
        for (int i = 0; i < 600; i++) begin
            logic [15:0] d;
            d = (i % 50 == 7) ? 16'h8000 : (i % 50 == 8) ? 16'h7FFF : 16'($urandom);
            h_m[wp_m] = d;
            e = model(32, 15, wp_m);
            xfer(1'b1, d, q, q1, lat);
            chk($sformatf("rand_%0d", i), 32'(q), 32'(e));
            if (i == 0) chk("small_latency", 32'(lat), 32'd36);
            wp_m = (wp_m + 1) & 31;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
